// File: rtl/axi4_burst_master.sv
// AXI4 initiator: one INCR burst per command, one burst in flight, streams beats in and out.
module axi4_burst_master #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    // command
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [2:0]            cmd_size,
    // write stream
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    // read stream
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [1:0]            rd_resp,
    output logic                  rd_last,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    // completion
    output logic                  done,
    output logic [1:0]            done_resp,
    // AXI write address
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic [7:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    // AXI write data
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,
    // AXI write response
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    // AXI read address
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [7:0]            ARLEN,
    output logic [2:0]            ARSIZE,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    // AXI read data
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RLAST,
    input  logic                  RVALID,
    output logic                  RREADY
);

    localparam int unsigned MAX_SIZE = $clog2(DATA_WIDTH / 8);
    localparam int unsigned CNT_W    = 9;
    localparam int unsigned SPAN_W   = 17;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AW   = 3'd1,
        S_W    = 3'd2,
        S_B    = 3'd3,
        S_AR   = 3'd4,
        S_R    = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    state_t                state_q,      state_d;
    logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
    logic [7:0]            len_q,        len_d;
    logic [2:0]            size_q,       size_d;
    logic                  awvalid_q,    awvalid_d;
    logic                  arvalid_q,    arvalid_d;
    logic                  bready_q,     bready_d;
    logic                  cmd_ready_q,  cmd_ready_d;
    logic                  done_q,       done_d;
    logic [1:0]            done_resp_q,  done_resp_d;
    logic [CNT_W-1:0]      beats_rem_q,  beats_rem_d;
    logic [1:0]            worst_resp_q, worst_resp_d;
    logic                  lerr_q,       lerr_d;

    logic [SPAN_W-1:0]     span_c;
    logic [SPAN_W-1:0]     end_off_c;
    logic                  illegal_c;
    logic                  last_beat_c;
    logic [1:0]            resp_max_c;
    logic                  lerr_now_c;

    // Legality of the incoming command: beat size fits the bus and burst stays inside one 4KB page
    always_comb begin
        span_c    = (SPAN_W'(cmd_len) + SPAN_W'(1)) << cmd_size;
        end_off_c = SPAN_W'(cmd_addr[11:0]) + span_c - SPAN_W'(1);
        illegal_c = (32'(cmd_size) > MAX_SIZE) || (end_off_c > SPAN_W'(12'hFFF));
    end

    // Per-beat helpers shared by the W and R phases
    always_comb begin
        last_beat_c = (beats_rem_q == CNT_W'(1));
        resp_max_c  = (RRESP > worst_resp_q) ? RRESP : worst_resp_q;
        lerr_now_c  = lerr_q | (RLAST != last_beat_c);
    end

    // State register and registered outputs
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            size_q       <= '0;
            awvalid_q    <= 1'b0;
            arvalid_q    <= 1'b0;
            bready_q     <= 1'b0;
            cmd_ready_q  <= 1'b1;
            done_q       <= 1'b0;
            done_resp_q  <= '0;
            beats_rem_q  <= '0;
            worst_resp_q <= '0;
            lerr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            size_q       <= size_d;
            awvalid_q    <= awvalid_d;
            arvalid_q    <= arvalid_d;
            bready_q     <= bready_d;
            cmd_ready_q  <= cmd_ready_d;
            done_q       <= done_d;
            done_resp_q  <= done_resp_d;
            beats_rem_q  <= beats_rem_d;
            worst_resp_q <= worst_resp_d;
            lerr_q       <= lerr_d;
        end
    end

    // Next-state and next-output logic for the burst sequencer
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        size_d       = size_q;
        awvalid_d    = awvalid_q;
        arvalid_d    = arvalid_q;
        bready_d     = bready_q;
        cmd_ready_d  = cmd_ready_q;
        done_d       = 1'b0;
        done_resp_d  = done_resp_q;
        beats_rem_d  = beats_rem_q;
        worst_resp_d = worst_resp_q;
        lerr_d       = lerr_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d       = cmd_addr;
                    len_d        = cmd_len;
                    size_d       = cmd_size;
                    cmd_ready_d  = 1'b0;
                    worst_resp_d = '0;
                    lerr_d       = 1'b0;
                    if (illegal_c) begin
                        state_d = S_ERR;
                    end else if (cmd_write) begin
                        state_d   = S_AW;
                        awvalid_d = 1'b1;
                    end else begin
                        state_d   = S_AR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            S_AW: begin
                if (AWREADY) begin
                    awvalid_d   = 1'b0;
                    beats_rem_d = CNT_W'(len_q) + CNT_W'(1);
                    state_d     = S_W;
                end
            end
            S_W: begin
                if (wr_valid && WREADY) begin
                    beats_rem_d = beats_rem_q - CNT_W'(1);
                    if (last_beat_c) begin
                        bready_d = 1'b1;
                        state_d  = S_B;
                    end
                end
            end
            S_B: begin
                if (BVALID) begin
                    bready_d    = 1'b0;
                    done_d      = 1'b1;
                    done_resp_d = BRESP;
                    cmd_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_AR: begin
                if (ARREADY) begin
                    arvalid_d   = 1'b0;
                    beats_rem_d = CNT_W'(len_q) + CNT_W'(1);
                    state_d     = S_R;
                end
            end
            S_R: begin
                if (RVALID && rd_ready) begin
                    beats_rem_d  = beats_rem_q - CNT_W'(1);
                    worst_resp_d = resp_max_c;
                    lerr_d       = lerr_now_c;
                    if (last_beat_c) begin
                        done_d      = 1'b1;
                        done_resp_d = lerr_now_c ? 2'b11 : resp_max_c;
                        cmd_ready_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
            end
            S_ERR: begin
                done_d      = 1'b1;
                done_resp_d = 2'b10;
                cmd_ready_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered outputs; address/len/size shared by both address channels
    assign cmd_ready = cmd_ready_q;
    assign done      = done_q;
    assign done_resp = done_resp_q;
    assign AWADDR    = addr_q;
    assign AWLEN     = len_q;
    assign AWSIZE    = size_q;
    assign AWVALID   = awvalid_q;
    assign ARADDR    = addr_q;
    assign ARLEN     = len_q;
    assign ARSIZE    = size_q;
    assign ARVALID   = arvalid_q;
    assign BREADY    = bready_q;

    // Write-stream pass-through, quiet outside the W phase
    always_comb begin
        WVALID   = (state_q == S_W) && wr_valid;
        WDATA    = (state_q == S_W) ? wr_data : '0;
        WLAST    = (state_q == S_W) && last_beat_c;
        wr_ready = (state_q == S_W) && WREADY;
    end

    // Read-stream pass-through, quiet outside the R phase
    always_comb begin
        rd_valid = (state_q == S_R) && RVALID;
        rd_data  = (state_q == S_R) ? RDATA : '0;
        rd_resp  = (state_q == S_R) ? RRESP : 2'b00;
        rd_last  = (state_q == S_R) && RLAST;
        RREADY   = (state_q == S_R) && rd_ready;
    end

endmodule

// File: tb/tb_axi4_burst_master.sv
// Directed bench for axi4_burst_master: writes, reads, illegal commands, mid-burst reset.
module tb_axi4_burst_master;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 16;

    logic          ACLK = 1'b0;
    logic          ARESETn = 1'b0;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [7:0]    cmd_len = '0;
    logic [2:0]    cmd_size = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_valid = 1'b0, wr_ready;
    logic [DW-1:0] rd_data;
    logic [1:0]    rd_resp;
    logic          rd_last, rd_valid, rd_ready = 1'b0;
    logic          done;
    logic [1:0]    done_resp;
    logic [AW-1:0] AWADDR, ARADDR;
    logic [7:0]    AWLEN, ARLEN;
    logic [2:0]    AWSIZE, ARSIZE;
    logic          AWVALID, AWREADY = 1'b0, ARVALID, ARREADY = 1'b0;
    logic [DW-1:0] WDATA;
    logic          WLAST, WVALID, WREADY = 1'b0;
    logic [1:0]    BRESP = '0;
    logic          BVALID = 1'b0, BREADY;
    logic [DW-1:0] RDATA = '0;
    logic [1:0]    RRESP = '0;
    logic          RLAST = 1'b0, RVALID = 1'b0, RREADY;

    int n_checks = 0;
    int n_errors = 0;

    always #5 ACLK = ~ACLK;

    axi4_burst_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_resp(rd_resp), .rd_last(rd_last),
        .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done(done), .done_resp(done_resp),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    // Count one comparison and report it when observed differs from expected
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one command for a single cycle
    task automatic send_cmd(input logic wr, input logic [15:0] a, input logic [7:0] l, input logic [2:0] s);
        @(negedge ACLK);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_size  = s;
        @(negedge ACLK);
        cmd_valid = 1'b0;
    endtask

    // Full write burst; optional AWREADY stall and toggling wr_valid/WREADY
    task automatic do_write(input logic [15:0] a, input logic [7:0] l, input logic [2:0] s,
                            input int aw_wait, input bit tog, input logic [1:0] bresp,
                            input logic [31:0] dbase);
        int beat;
        int cyc;
        AWREADY = (aw_wait == 0);
        send_cmd(1'b1, a, l, s);
        check("aw_valid", 32'(AWVALID), 32'd1);
        check("aw_addr", 32'(AWADDR), 32'(a));
        check("aw_len", 32'(AWLEN), 32'(l));
        check("aw_size", 32'(AWSIZE), 32'(s));
        check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
        for (int i = 0; i < aw_wait; i++) begin
            @(negedge ACLK);
            check("aw_hold_valid", 32'(AWVALID), 32'd1);
            check("aw_hold_addr", 32'(AWADDR), 32'(a));
        end
        AWREADY = 1'b1;
        beat = 0;
        cyc  = 0;
        while (cyc < 200) begin
            @(negedge ACLK);
            AWREADY = 1'b0;
            if (BREADY) break;
            wr_data  = dbase + 32'(beat);
            wr_valid = tog ? (cyc % 3 != 2) : 1'b1;
            WREADY   = tog ? (cyc % 2 == 0) : 1'b1;
            #1;
            if (WVALID && WREADY) begin
                check("w_data", WDATA, dbase + 32'(beat));
                check("w_last", 32'(WLAST), 32'(beat == int'(l)));
                check("wr_ready", 32'(wr_ready), 32'd1);
                beat++;
            end
            cyc++;
        end
        check("w_no_timeout", 32'(cyc < 200), 32'd1);
        check("w_beats", 32'(beat), 32'(l) + 32'd1);
        wr_valid = 1'b0;
        WREADY   = 1'b0;
        BVALID   = 1'b1;
        BRESP    = bresp;
        @(negedge ACLK);
        BVALID = 1'b0;
        check("wdone", 32'(done), 32'd1);
        check("wdone_resp", 32'(done_resp), 32'(bresp));
        check("wdone_cmd_ready", 32'(cmd_ready), 32'd1);
        check("b_ready_drop", 32'(BREADY), 32'd0);
        @(negedge ACLK);
        check("wdone_pulse", 32'(done), 32'd0);
    endtask

    // Full read burst; rlast_at<0 gives a correct RLAST, bad_beat carries RRESP=10
    task automatic do_read(input logic [15:0] a, input logic [7:0] l, input logic [2:0] s,
                           input int rlast_at, input int bad_beat, input logic [1:0] exp_resp);
        ARREADY  = 1'b1;
        rd_ready = 1'b1;
        send_cmd(1'b0, a, l, s);
        check("ar_valid", 32'(ARVALID), 32'd1);
        check("ar_addr", 32'(ARADDR), 32'(a));
        check("ar_len", 32'(ARLEN), 32'(l));
        check("ar_aw_quiet", 32'(AWVALID), 32'd0);
        for (int b = 0; b <= int'(l); b++) begin
            @(negedge ACLK);
            ARREADY = 1'b0;
            RVALID  = 1'b1;
            RDATA   = 32'hC0DE_0000 + 32'(b);
            RLAST   = (rlast_at < 0) ? (b == int'(l)) : (b == rlast_at);
            RRESP   = (b == bad_beat) ? 2'b10 : 2'b00;
            #1;
            check("r_valid", 32'(rd_valid), 32'd1);
            check("r_data", rd_data, 32'hC0DE_0000 + 32'(b));
            check("r_last", 32'(rd_last), 32'(RLAST));
            check("r_ready", 32'(RREADY), 32'd1);
        end
        @(negedge ACLK);
        RLAST  = 1'b0;
        RRESP  = 2'b00;
        #1;
        check("rdone", 32'(done), 32'd1);
        check("rdone_resp", 32'(done_resp), 32'(exp_resp));
        check("r_extra_not_taken", 32'(RREADY), 32'd0);
        check("r_extra_no_valid", 32'(rd_valid), 32'd0);
        RVALID   = 1'b0;
        rd_ready = 1'b0;
        @(negedge ACLK);
        check("rdone_pulse", 32'(done), 32'd0);
    endtask

    // Illegal command: no AXI traffic, done two cycles after presentation with SLVERR status
    task automatic do_illegal(input logic [15:0] a, input logic [7:0] l, input logic [2:0] s);
        send_cmd(1'b1, a, l, s);
        check("err_no_aw", 32'(AWVALID), 32'd0);
        check("err_no_ar", 32'(ARVALID), 32'd0);
        check("err_not_yet", 32'(done), 32'd0);
        @(negedge ACLK);
        check("err_done", 32'(done), 32'd1);
        check("err_resp", 32'(done_resp), 32'd2);
        check("err_cmd_ready", 32'(cmd_ready), 32'd1);
        check("err_no_aw2", 32'(AWVALID), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge ACLK);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_awvalid", 32'(AWVALID), 32'd0);
        check("rst_arvalid", 32'(ARVALID), 32'd0);
        check("rst_bready", 32'(BREADY), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_done_resp", 32'(done_resp), 32'd0);
        check("rst_awaddr", 32'(AWADDR), 32'd0);
        ARESETn = 1'b1;
        @(negedge ACLK);

        do_write(16'h0010, 8'd3, 3'd2, 0, 1'b0, 2'b00, 32'h0000_00A0);
        do_read(16'h0100, 8'd0, 3'd2, -1, -1, 2'b00);
        do_write(16'h0040, 8'd3, 3'd2, 5, 1'b1, 2'b01, 32'h0000_0B00);
        do_illegal(16'h0FF8, 8'd3, 3'd2);
        do_illegal(16'h0000, 8'd0, 3'd3);
        do_read(16'h0FF0, 8'd3, 3'd2, -1, -1, 2'b00);
        do_read(16'h0200, 8'd3, 3'd2, 2, -1, 2'b11);
        do_read(16'h0300, 8'd3, 3'd2, -1, 1, 2'b10);
        do_write(16'h0400, 8'd0, 3'd1, 0, 1'b0, 2'b00, 32'h0000_5A5A);

        // Reset in the middle of a write burst
        AWREADY = 1'b1;
        send_cmd(1'b1, 16'h0500, 8'd7, 3'd2);
        AWREADY  = 1'b0;
        wr_valid = 1'b1;
        WREADY   = 1'b1;
        repeat (3) @(negedge ACLK);
        ARESETn = 1'b0;
        #1;
        check("mid_rst_wvalid", 32'(WVALID), 32'd0);
        check("mid_rst_wr_ready", 32'(wr_ready), 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_awaddr", 32'(AWADDR), 32'd0);
        check("mid_rst_bready", 32'(BREADY), 32'd0);
        @(negedge ACLK);
        wr_valid = 1'b0;
        WREADY   = 1'b0;
        ARESETn  = 1'b1;
        @(negedge ACLK);
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        do_write(16'h0600, 8'd2, 3'd2, 1, 1'b0, 2'b00, 32'h0000_0600);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Absolute watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
